// File: rtl/pipeline_regs_pkg.sv
// Shared pipeline-register types: per-stage payload structs, their NOP/bubble
// encodings, and the stage occupancy state used by pipeline_stage_reg.
package pipeline_regs_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } FD_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } DE_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } EM_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } MW_t;

  // Bubbles must never write state: all enables low, fetch slot carries a NOP.
  localparam FD_t FD_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR};
  localparam DE_t DE_BUBBLE = '{default: '0};
  localparam EM_t EM_BUBBLE = '{default: '0};
  localparam MW_t MW_BUBBLE = '{default: '0};

  function automatic logic [1:0] occ_of(input stage_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// Elastic valid/ready pipeline latch with optional two-entry skid buffer,
// flush-to-bubble, hold/freeze and a saturating downstream-stall counter.
module pipeline_stage_reg
  import pipeline_regs_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter bit               SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNTW   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_count
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [CNTW-1:0]  stall_q, stall_d;

  logic gate;
  logic accept;
  logic deliver;

  assign gate    = hold | flush;
  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] skid_q, skid_d;

      // Handshake outputs depend on state only, so out_ready never reaches in_ready.
      always_comb begin
        in_ready  = !gate && (state_q != TWO);
        out_valid = !gate && (state_q != EMPTY);
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                state_d = ONE;
                main_d  = in_data;
              end
            end
            ONE: begin
              if (accept && deliver) begin
                main_d = in_data;
              end else if (accept) begin
                state_d = TWO;
                skid_d  = in_data;
              end else if (deliver) begin
                state_d = EMPTY;
                main_d  = BUBBLE;
              end
            end
            TWO: begin
              if (deliver) begin
                state_d = ONE;
                main_d  = skid_q;
                skid_d  = BUBBLE;
              end
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          skid_q <= BUBBLE;
        end else begin
          skid_q <= skid_d;
        end
      end
    end else begin : g_noskid
      logic full;

      // ONE doubles as FULL; TWO is unreachable in this variant.
      assign full = (state_q != EMPTY);

      always_comb begin
        in_ready  = !gate && (!full || out_ready);
        out_valid = !gate && full;
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end else if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end else if (deliver) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
    end
  endgenerate

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + CNTW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      stall_q <= stall_d;
    end
  end

  assign out_data    = main_q;
  assign occupancy   = occ_of(state_q);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench: dut1 is the skid variant (CNTW=4, NOP bubble), dut0 the
// single-register variant; a monitor per instance checks delivered order.
module tb_pipeline_stage_reg;

  localparam logic [31:0] BUB1 = 32'h0000_0013;
  localparam logic [31:0] BUB0 = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v1, r1, ov1, or1, fl1, hd1;
  logic [31:0] d1, od1;
  logic [1:0]  occ1;
  logic [3:0]  st1;

  logic        v0, r0, ov0, or0, fl0, hd0;
  logic [31:0] d0, od0;
  logic [1:0]  occ0;
  logic [15:0] st0;

  pipeline_stage_reg #(
    .WIDTH(32), .SKID(1'b1), .BUBBLE(BUB1), .CNTW(4)
  ) dut1 (
    .CLK(clk), .nRST(rst_n),
    .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .flush(fl1), .hold(hd1), .occupancy(occ1), .stall_count(st1)
  );

  pipeline_stage_reg #(
    .WIDTH(32), .SKID(1'b0), .BUBBLE(BUB0), .CNTW(16)
  ) dut0 (
    .CLK(clk), .nRST(rst_n),
    .in_valid(v0), .in_ready(r0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .flush(fl0), .hold(hd0), .occupancy(occ0), .stall_count(st0)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv1(input logic v, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic hd);
    v1 = v; d1 = d; or1 = ordy; fl1 = fl; hd1 = hd;
  endtask

  // Scoreboard push: payload the bench drove is expected once it is accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fl1) q1.delete();
      else if (v1 && r1) q1.push_back(d1);
      if (v0 && r0) q0.push_back(d0);
    end
  end

  // Monitors: compare each delivered payload against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut1_extra: got %h, expected no delivery", od1);
      end else begin
        chk("dut1_order", od1, q1.pop_front());
      end
    end
    if (rst_n && ov0 && or0) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut0_extra: got %h, expected no delivery", od0);
      end else begin
        chk("dut0_order", od0, q0.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] exp_st;
    logic        full;
    logic        acc;
    logic [31:0] idx;
    logic [31:0] exp_st0;

    rst_n = 1'b0;
    drv1(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    v0 = 1'b0; d0 = 32'h0; or0 = 1'b0; fl0 = 1'b0; hd0 = 1'b0;

    // Reset state
    smp();
    chk("rst_out_valid", 32'(ov1), 32'd0);
    chk("rst_out_data", od1, BUB1);
    chk("rst_occupancy", 32'(occ1), 32'd0);
    chk("rst_stall", 32'(st1), 32'd0);
    chk("rst_in_ready", 32'(r1), 32'd1);
    tick();
    rst_n = 1'b1;

    // Single transfer, one-cycle latency
    drv1(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    smp(); chk("t1_in_ready", 32'(r1), 32'd1);
    tick();
    drv1(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    smp();
    chk("t1_out_valid", 32'(ov1), 32'd1);
    chk("t1_out_data", od1, 32'hDEAD_BEEF);
    chk("t1_occupancy", 32'(occ1), 32'd1);
    tick();
    smp(); chk("t1_drained", 32'(occ1), 32'd0);
    tick();

    // A, B, C with a one-cycle out_ready drop after A
    drv1(1'b1, 32'hA, 1'b1, 1'b0, 1'b0); smp(); chk("t2_occ0", 32'(occ1), 32'd0); tick();
    drv1(1'b1, 32'hB, 1'b0, 1'b0, 1'b0); smp(); chk("t2_occ1", 32'(occ1), 32'd1);
    chk("t2_rdy1", 32'(r1), 32'd1); tick();
    drv1(1'b1, 32'hC, 1'b1, 1'b0, 1'b0); smp(); chk("t2_occ2", 32'(occ1), 32'd2);
    chk("t2_rdy_full", 32'(r1), 32'd0); chk("t2_valid_full", 32'(ov1), 32'd1); tick();
    drv1(1'b1, 32'hC, 1'b1, 1'b0, 1'b0); smp(); chk("t2_occ_back", 32'(occ1), 32'd1);
    chk("t2_rdy_back", 32'(r1), 32'd1); tick();
    drv1(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); smp(); chk("t2_occ_last", 32'(occ1), 32'd1); tick();
    smp(); chk("t2_occ_end", 32'(occ1), 32'd0); chk("t2_stall", 32'(st1), 32'd1); tick();

    // Flush while full with input offered
    drv1(1'b1, 32'hD, 1'b0, 1'b0, 1'b0); smp(); tick();
    drv1(1'b1, 32'hE, 1'b0, 1'b0, 1'b0); smp(); chk("t3_occ1", 32'(occ1), 32'd1); tick();
    drv1(1'b1, 32'hF, 1'b0, 1'b1, 1'b0); smp();
    chk("t3_flush_rdy", 32'(r1), 32'd0); chk("t3_flush_valid", 32'(ov1), 32'd0);
    chk("t3_flush_occ_pre", 32'(occ1), 32'd2); tick();
    drv1(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); smp();
    chk("t3_occ", 32'(occ1), 32'd0); chk("t3_valid", 32'(ov1), 32'd0);
    chk("t3_bubble", od1, BUB1); chk("t3_stall", 32'(st1), 32'd2); tick();

    // Hold for 3 cycles while full
    drv1(1'b1, 32'h6, 1'b0, 1'b0, 1'b0); smp(); tick();
    drv1(1'b1, 32'h7, 1'b0, 1'b0, 1'b0); smp(); tick();
    for (int k = 0; k < 3; k++) begin
      drv1(1'b1, 32'h8, 1'b1, 1'b0, 1'b1); smp();
      chk("t4_hold_valid", 32'(ov1), 32'd0); chk("t4_hold_rdy", 32'(r1), 32'd0);
      chk("t4_hold_occ", 32'(occ1), 32'd2); chk("t4_hold_data", od1, 32'h6);
      chk("t4_hold_stall", 32'(st1), 32'd3); tick();
    end
    drv1(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); smp();
    chk("t4_resume_valid", 32'(ov1), 32'd1); chk("t4_resume_occ", 32'(occ1), 32'd2); tick();
    smp(); chk("t4_second", od1, 32'h7); tick();
    smp(); chk("t4_drained", 32'(occ1), 32'd0); tick();

    // Stall counter saturation (CNTW=4)
    drv1(1'b1, 32'h9, 1'b0, 1'b0, 1'b0); smp(); tick();
    drv1(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_st = 32'd3;
    for (int k = 0; k < 20; k++) begin
      smp(); chk("t5_stall", 32'(st1), exp_st);
      if (exp_st < 32'd15) exp_st = exp_st + 32'd1;
      tick();
    end
    drv1(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); smp(); chk("t5_sat", 32'(st1), 32'd15); tick();
    smp(); chk("t5_drained", 32'(occ1), 32'd0); tick();

    // Asynchronous reset mid-transfer
    drv1(1'b1, 32'h5A5A, 1'b0, 1'b0, 1'b0); smp(); tick();
    drv1(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    q1.delete(); q0.delete();
    #1;
    chk("t6_async_valid", 32'(ov1), 32'd0); chk("t6_async_data", od1, BUB1);
    chk("t6_async_occ", 32'(occ1), 32'd0); chk("t6_async_stall", 32'(st1), 32'd0);
    smp(); tick();
    rst_n = 1'b1;
    smp(); chk("t6_rdy_after", 32'(r1), 32'd1); chk("t6_occ_after", 32'(occ1), 32'd0); tick();

    // SKID=0: continuous input, out_ready toggling
    smp();
    chk("t7_rst_valid", 32'(ov0), 32'd0); chk("t7_rst_data", od0, BUB0);
    tick();
    full = 1'b0; idx = 32'd0; exp_st0 = 32'd0;
    for (int c = 0; c < 16; c++) begin
      v0 = 1'b1; d0 = 32'h100 + idx; or0 = c[0];
      smp();
      chk("t7_in_ready", 32'(r0), 32'(!full || or0));
      chk("t7_occ", 32'(occ0), 32'(full));
      chk("t7_valid", 32'(ov0), 32'(full));
      if (full && !or0) exp_st0 = exp_st0 + 32'd1;
      acc = !full || or0;
      if (acc) begin
        full = 1'b1;
        idx = idx + 32'd1;
      end else if (full && or0) begin
        full = 1'b0;
      end
      tick();
    end
    v0 = 1'b0; or0 = 1'b1;
    smp(); tick();
    smp();
    chk("t7_drained", 32'(occ0), 32'd0);
    chk("t7_stall", 32'(st0), exp_st0);
    chk("t7_no_loss", 32'(q0.size()), 32'd0);
    chk("t2_no_loss", 32'(q1.size()), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Parametrised elastic pipeline latch that replaces the fixed FD/DE/EM/MW register banks with one reusable stage. Carries an opaque payload of WIDTH bits (one of the `pipeline_regs_pkg` structs, flattened) with valid/ready handshaking, an optional two-entry skid buffer, synchronous flush-to-bubble, a hold (freeze) input and a saturating stall counter. One instance sits between each pair of adjacent stages (F/D, D/E, E/M, M/W).

## Interface
- WIDTH, 64, payload bits; set from `$bits(FD_t)`, `$bits(DE_t)`, etc.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational ready pass-through.
- BUBBLE, '0, WIDTH-bit payload driven when the stage is empty or flushed (NOP encoding).
- CNTW, 16, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has payload.
- in_ready  out  1  stage accepts payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage presents payload.
- out_ready  in  1  downstream accepts payload.
- out_data  out  WIDTH  head payload; BUBBLE when empty.
- flush  in  1  discard all contents this cycle.
- hold  in  1  freeze: no transfer on either side.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_count  out  CNTW  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Accept = in_valid & in_ready; deliver = out_valid & out_ready.
- in_ready and out_valid are both forced 0 while hold=1 or flush=1; no transfer occurs, contents are unchanged under hold.
- Flush has priority over everything: next state EMPTY, main and skid entries <= BUBBLE, occupancy <= 0. The flush-cycle input is not accepted.
- SKID=1, states EMPTY/ONE/TWO; in_ready = (state != TWO); out_valid = (state != EMPTY); out_data = main register.
  - EMPTY + accept -> ONE, main <= in_data.
  - ONE + accept + deliver -> ONE, main <= in_data.
  - ONE + accept only -> TWO, skid <= in_data.
  - ONE + deliver only -> EMPTY, main <= BUBBLE.
  - TWO + deliver -> ONE, main <= skid, skid <= BUBBLE. No accept is possible in TWO.
  - No event: the state holds.
- SKID=0, states EMPTY/FULL; in_ready = !full | out_ready (combinational from out_ready).
  - accept -> FULL, main <= in_data.
  - deliver without accept -> EMPTY, main <= BUBBLE.
- Order is preserved; a payload is never duplicated or dropped except by flush.
- stall_count increments when out_valid & !out_ready (evaluated after hold gating, so a held stage does not count), saturates at 2^CNTW-1, and is cleared only by reset.

## Timing
- Reset values: state EMPTY, out_valid 0, out_data BUBBLE, occupancy 0, stall_count 0; in_ready = !hold & !flush immediately after reset release.
- Latency: accepted in cycle N, visible at out_data/out_valid in cycle N+1.
- SKID=1: in_ready and out_valid depend only on state, hold and flush, with no path from out_ready. Throughput is 1/cycle; full throughput is sustained across a one-cycle out_ready drop with no bubble.
- SKID=0: throughput is 1/cycle with a combinational out_ready -> in_ready path.
- Reset asserted mid-transfer: the in-flight payload is lost, outputs go to reset values asynchronously, and the first edge after release has no effect on state.
- flush and hold asserted together: flush wins.

## Structure
- Stage structs (FD_t, DE_t, EM_t, MW_t) and a `stage_state_t` enum (EMPTY, ONE, TWO) live in `pipeline_regs_pkg`. BUBBLE constants per stage (`FD_BUBBLE`, etc.) are also defined there.
- No sub-module; the SKID variants are selected with a generate block inside the one module.

## Test plan
- Reset, then in_data=0xDEADBEEF, in_valid=1, out_ready=1 -> out_data=0xDEADBEEF, out_valid=1 the next cycle; occupancy=1.
- SKID=1, stream A, B, C with out_ready low for one cycle after A is accepted -> occupancy reaches 2, in_ready=0 for one cycle; output order is A, B, C with no loss.
- Flush with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_data=BUBBLE, out_valid=0; the flush-cycle input is not stored.
- Hold for 3 cycles while full and out_ready=1 -> out_valid=0, in_ready=0, contents unchanged, stall_count unchanged; released -> delivery resumes.
- CNTW=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_count saturates at 15.
- SKID=0, out_ready toggling every cycle with continuous input -> in_ready equals out_ready whenever full; no payload loss.
